// File: rtl/s100_pkg.sv
// Constants and state encoding shared by S100-side bus blocks.
package s100_pkg;

   localparam int unsigned WIDTH_DEF      = 8;
   localparam int unsigned ADDR_LINES_DEF = 16;
   localparam int unsigned WAIT_CNT_W     = 4;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS,
      HOLD
   } sram_state_t;

endpackage

// File: rtl/wb_sram_slave.sv
// Wishbone slave driving an asynchronous SRAM with programmable wait states.
// Optional write protection of an address window: define WB_SRAM_WRITE_PROTECT_EN.
module wb_sram_slave
   import s100_pkg::*;
#(
   parameter int unsigned           WIDTH       = WIDTH_DEF,
   parameter int unsigned           ADDR_LINES  = ADDR_LINES_DEF,
   parameter int unsigned           WAIT_STATES = 2,
   parameter logic [ADDR_LINES-1:0] WP_BASE     = 16'hF000,
   parameter logic [ADDR_LINES-1:0] WP_MASK     = 16'hF000
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_wb_cyc,
   input  logic                  i_wb_stb,
   input  logic                  i_wb_we,
   input  logic [ADDR_LINES-1:0] i_wb_addr,
   input  logic [WIDTH-1:0]      i_wb_data,
   output logic                  o_wb_ack,
   output logic                  o_wb_stall,
   output logic [WIDTH-1:0]      o_wb_data,
   output logic [ADDR_LINES-1:0] o_sram_addr,
   output logic [WIDTH-1:0]      o_sram_dq_out,
   output logic                  o_sram_dq_oe,
   input  logic [WIDTH-1:0]      i_sram_dq_in,
   output logic                  o_sram_ce_n,
   output logic                  o_sram_oe_n,
   output logic                  o_sram_we_n,
   output logic                  o_wp_fault
);

`ifdef WB_SRAM_WRITE_PROTECT_EN
   localparam bit WP_EN = 1'b1;
`else
   localparam bit WP_EN = 1'b0;
`endif

   // Declaration initialisers make power-up state match the reset state.
   sram_state_t           state_q = IDLE;
   sram_state_t           state_d;
   logic [WAIT_CNT_W-1:0] cnt_q   = '0;
   logic [WAIT_CNT_W-1:0] cnt_d;
   logic [ADDR_LINES-1:0] addr_q  = '0;
   logic [ADDR_LINES-1:0] addr_d;
   logic [WIDTH-1:0]      data_q  = '0;
   logic [WIDTH-1:0]      data_d;
   logic [WIDTH-1:0]      rdata_q = '0;
   logic [WIDTH-1:0]      rdata_d;
   logic                  we_q    = 1'b0;
   logic                  we_d;
   logic                  wp_q    = 1'b0;
   logic                  wp_d;
   logic                  abort_q = 1'b0;
   logic                  abort_d;
   logic                  ack_q   = 1'b0;
   logic                  ack_d;
   logic                  fault_q = 1'b0;
   logic                  fault_d;
   logic                  ce_n_q  = 1'b1;
   logic                  ce_n_d;
   logic                  oe_n_q  = 1'b1;
   logic                  oe_n_d;
   logic                  we_n_q  = 1'b1;
   logic                  we_n_d;
   logic                  dq_oe_q = 1'b0;
   logic                  dq_oe_d;

   logic wp_hit;
   logic req_wp;
   logic wr_active;

   assign wp_hit    = ((i_wb_addr & WP_MASK) == WP_BASE);
   assign req_wp    = WP_EN && i_wb_we && wp_hit;
   // A blocked write runs the full cycle but never drives the bus or strobes we_n.
   assign wr_active = we_q && !wp_q;

   always_comb begin
      // NOTE: every _d gets a default before the case so no path infers a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      data_d  = data_q;
      rdata_d = rdata_q;
      we_d    = we_q;
      wp_d    = wp_q;
      abort_d = abort_q;
      ack_d   = 1'b0;
      fault_d = 1'b0;
      ce_n_d  = 1'b1;
      oe_n_d  = 1'b1;
      we_n_d  = 1'b1;
      dq_oe_d = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (i_wb_cyc && i_wb_stb) begin
               state_d = SETUP;
               addr_d  = i_wb_addr;
               data_d  = i_wb_data;
               we_d    = i_wb_we;
               wp_d    = req_wp;
               abort_d = 1'b0;
               ce_n_d  = 1'b0;
               oe_n_d  = i_wb_we;
               dq_oe_d = i_wb_we && !req_wp;
            end
         end
         SETUP: begin
            state_d = ACCESS;
            cnt_d   = WAIT_CNT_W'(WAIT_STATES);
            abort_d = abort_q || !i_wb_cyc;
            ce_n_d  = 1'b0;
            oe_n_d  = we_q;
            we_n_d  = !wr_active;
            dq_oe_d = wr_active;
         end
         ACCESS: begin
            abort_d = abort_q || !i_wb_cyc;
            ce_n_d  = 1'b0;
            dq_oe_d = wr_active;
            if (cnt_q == '0) begin
               state_d = HOLD;
               if (!we_q) rdata_d = i_sram_dq_in;
               ack_d   = !abort_q && i_wb_cyc;
               fault_d = wp_q && !abort_q && i_wb_cyc;
            end else begin
               cnt_d  = cnt_q - WAIT_CNT_W'(1);
               oe_n_d = we_q;
               we_n_d = !wr_active;
            end
         end
         HOLD: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (i_rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         rdata_q <= '0;
         we_q    <= 1'b0;
         wp_q    <= 1'b0;
         abort_q <= 1'b0;
         ack_q   <= 1'b0;
         fault_q <= 1'b0;
         ce_n_q  <= 1'b1;
         oe_n_q  <= 1'b1;
         we_n_q  <= 1'b1;
         dq_oe_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         rdata_q <= rdata_d;
         we_q    <= we_d;
         wp_q    <= wp_d;
         abort_q <= abort_d;
         ack_q   <= ack_d;
         fault_q <= fault_d;
         ce_n_q  <= ce_n_d;
         oe_n_q  <= oe_n_d;
         we_n_q  <= we_n_d;
         dq_oe_q <= dq_oe_d;
      end
   end

   // Master abandoning the cycle during HOLD must never see an ack.
   assign o_wb_ack      = ack_q && i_wb_cyc;
   assign o_wp_fault    = fault_q && i_wb_cyc;
   assign o_wb_stall    = (state_q != IDLE);
   assign o_wb_data     = rdata_q;
   assign o_sram_addr   = addr_q;
   assign o_sram_dq_out = data_q;
   assign o_sram_dq_oe  = dq_oe_q;
   assign o_sram_ce_n   = ce_n_q;
   assign o_sram_oe_n   = oe_n_q;
   assign o_sram_we_n   = we_n_q;

endmodule

// File: tb/tb_wb_sram_slave.sv
// Randomized bench for wb_sram_slave with a memory-level reference model.
module tb_wb_sram_slave;

   localparam int WS = 2;

`ifdef WB_SRAM_WRITE_PROTECT_EN
   localparam bit WP_ON = 1'b1;
`else
   localparam bit WP_ON = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // Main DUT, WAIT_STATES = 2
   logic        cyc, stb, wwe;
   logic [15:0] waddr;
   logic [7:0]  wdata;
   logic        ack, stall, dq_oe, ce_n, oe_n, we_n, fault;
   logic [7:0]  rdata, dq_out, dq_in;
   logic [15:0] sram_addr;

   // Second DUT, WAIT_STATES = 0
   logic        z_cyc, z_stb, z_we;
   logic [15:0] z_addr;
   logic [7:0]  z_wdata;
   logic        z_ack, z_stall, z_dq_oe, z_ce_n, z_oe_n, z_we_n, z_fault;
   logic [7:0]  z_rdata, z_dq_out, z_dq_in;
   logic [15:0] z_sram_addr;

   logic [7:0] sram_mem [0:65535];
   logic [7:0] ref_mem  [0:65535];
   logic [7:0] z_mem    [0:255];
   logic [7:0] last_rd;

   int n_checks = 0;
   int n_fail   = 0;

   wb_sram_slave #(.WAIT_STATES(WS)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(wwe),
      .i_wb_addr(waddr), .i_wb_data(wdata),
      .o_wb_ack(ack), .o_wb_stall(stall), .o_wb_data(rdata),
      .o_sram_addr(sram_addr), .o_sram_dq_out(dq_out), .o_sram_dq_oe(dq_oe),
      .i_sram_dq_in(dq_in),
      .o_sram_ce_n(ce_n), .o_sram_oe_n(oe_n), .o_sram_we_n(we_n),
      .o_wp_fault(fault)
   );

   wb_sram_slave #(.WAIT_STATES(0)) dut_z (
      .i_clk(clk), .i_rst(rst),
      .i_wb_cyc(z_cyc), .i_wb_stb(z_stb), .i_wb_we(z_we),
      .i_wb_addr(z_addr), .i_wb_data(z_wdata),
      .o_wb_ack(z_ack), .o_wb_stall(z_stall), .o_wb_data(z_rdata),
      .o_sram_addr(z_sram_addr), .o_sram_dq_out(z_dq_out), .o_sram_dq_oe(z_dq_oe),
      .i_sram_dq_in(z_dq_in),
      .o_sram_ce_n(z_ce_n), .o_sram_oe_n(z_oe_n), .o_sram_we_n(z_we_n),
      .o_wp_fault(z_fault)
   );

   // Behavioural asynchronous SRAMs attached to each DUT.
   assign dq_in   = sram_mem[sram_addr];
   assign z_dq_in = z_mem[z_sram_addr[7:0]];

   always @(posedge clk) begin
      if (!ce_n && !we_n) sram_mem[sram_addr] <= dq_out;
      if (!z_ce_n && !z_we_n) z_mem[z_sram_addr[7:0]] <= z_dq_out;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One Wishbone transaction on the main DUT, with cycle-by-cycle observation.
   task automatic wb_txn(input bit we, input logic [15:0] addr, input logic [7:0] data,
                         input bit drop_cyc);
      bit         prot;
      int         we_lo, oe_lo, ce_lo, oe_drv, ack_k, fault_k, idle_k;
      bit         viol, dq_bad, addr_bad;
      logic [7:0] exp_rd;
      prot     = we && WP_ON && ((addr & 16'hF000) == 16'hF000);
      exp_rd   = we ? last_rd : ref_mem[addr];
      we_lo    = 0; oe_lo = 0; ce_lo = 0; oe_drv = 0;
      ack_k    = 0; fault_k = 0; idle_k = 0;
      viol     = 1'b0; dq_bad = 1'b0; addr_bad = 1'b0;

      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; wwe = we; waddr = addr; wdata = data;
      check("stall_before_accept", stall, 0);
      @(posedge clk);
      #1;
      stb = 1'b0;
      if (drop_cyc) cyc = 1'b0;
      for (int k = 1; k <= WS + 4; k++) begin
         @(negedge clk);
         if (!we_n) begin
            we_lo++;
            if (dq_out !== data) dq_bad = 1'b1;
         end
         if (!oe_n) oe_lo++;
         if (!ce_n) ce_lo++;
         if (dq_oe) oe_drv++;
         if ((!we_n && !oe_n) || (dq_oe && !oe_n)) viol = 1'b1;
         if (!ce_n && sram_addr !== addr) addr_bad = 1'b1;
         if (ack) ack_k = (ack_k == 0) ? k : -1;
         if (fault) fault_k = k;
         if (!stall && idle_k == 0) idle_k = k;
         if (k == WS + 3) check("rdata_at_hold", rdata, exp_rd);
      end
      cyc = 1'b0;

      check("we_n_low_cycles", we_lo, (we && !prot) ? WS + 1 : 0);
      check("oe_n_low_cycles", oe_lo, we ? 0 : WS + 2);
      check("ce_n_low_cycles", ce_lo, WS + 3);
      check("dq_oe_cycles", oe_drv, (we && !prot) ? WS + 3 : 0);
      check("ack_cycle", ack_k, drop_cyc ? 0 : WS + 3);
      check("fault_cycle", fault_k, (prot && !drop_cyc) ? WS + 3 : 0);
      check("first_idle_cycle", idle_k, WS + 4);
      check("strobe_conflict", viol, 0);
      check("dq_out_value", dq_bad, 0);
      check("sram_addr_value", addr_bad, 0);

      if (we && !prot) ref_mem[addr] = data;
      if (!we) last_rd = ref_mem[addr];
   endtask

   initial begin
      logic [15:0] a;
      logic [7:0]  d;
      int          z_ack1, z_ack2, z_idle;
      bit          saw_ack;

      for (int i = 0; i < 65536; i++) begin
         d = 8'(i) ^ 8'(i >> 8) ^ 8'h5A;
         sram_mem[i] = d;
         ref_mem[i]  = d;
      end
      for (int i = 0; i < 256; i++) z_mem[i] = 8'h00;

      rst = 1'b1;
      cyc = 0; stb = 0; wwe = 0; waddr = '0; wdata = '0;
      z_cyc = 0; z_stb = 0; z_we = 0; z_addr = '0; z_wdata = '0;
      last_rd = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_stall", stall, 0);
      check("rst_ack", ack, 0);
      check("rst_fault", fault, 0);
      check("rst_strobes", {ce_n, oe_n, we_n}, 3'b111);
      check("rst_dq_oe", dq_oe, 0);
      check("rst_rdata", rdata, 0);
      check("rst_sram_addr", sram_addr, 0);
      rst = 1'b0;

      // Directed: write/read at 0x1234, then read a different value.
      wb_txn(1'b1, 16'h1234, 8'hA5, 1'b0);
      wb_txn(1'b0, 16'h1234, 8'h00, 1'b0);
      check("readback_a5", rdata, 8'hA5);
      wb_txn(1'b1, 16'h1234, 8'h3C, 1'b0);
      wb_txn(1'b0, 16'h1234, 8'h00, 1'b0);
      check("readback_3c", rdata, 8'h3C);

      // Write-protect window, then read-back.
      wb_txn(1'b1, 16'hF010, 8'h55, 1'b0);
      wb_txn(1'b0, 16'hF010, 8'h00, 1'b0);

      // Master drops cyc during SETUP of a read.
      wb_txn(1'b0, 16'h0007, 8'h00, 1'b1);

      // Reset during ACCESS of a write.
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; wwe = 1'b1; waddr = 16'h0ABC; wdata = 8'h99;
      @(posedge clk);
      #1;
      stb = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("abort_we_n_before_rst", we_n, 0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("abort_we_n", we_n, 1);
      check("abort_ce_n", ce_n, 1);
      check("abort_dq_oe", dq_oe, 0);
      check("abort_stall", stall, 0);
      @(negedge clk);
      rst = 1'b0;
      saw_ack = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (ack) saw_ack = 1'b1;
      end
      check("abort_no_ack", saw_ack, 0);
      cyc = 1'b0;
      last_rd = 8'h00;

      wb_txn(1'b1, 16'h0003, 8'hC3, 1'b0);
      wb_txn(1'b0, 16'h0003, 8'h00, 1'b0);

      // Randomized traffic.
      for (int n = 0; n < 40; n++) begin
         case ($urandom_range(0, 2))
            0:       a = 16'h0000 | 16'($urandom_range(0, 15));
            1:       a = 16'hF000 | 16'($urandom_range(0, 15));
            default: a = 16'h1234;
         endcase
         d = 8'($urandom);
         wb_txn(1'($urandom_range(0, 1)), a, d, ($urandom_range(0, 7) == 0));
      end

      // WAIT_STATES = 0: back-to-back write then read, request held while stalled.
      z_ack1 = 0; z_ack2 = 0; z_idle = 0;
      d = 8'($urandom);
      @(negedge clk);
      z_cyc = 1'b1; z_stb = 1'b1; z_we = 1'b1; z_addr = 16'h0042; z_wdata = d;
      @(posedge clk);
      #1;
      z_we = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         @(negedge clk);
         if (z_ack) begin
            if (z_ack1 == 0) z_ack1 = k;
            else z_ack2 = k;
         end
         if (k == 7) check("ws0_rdata", z_rdata, d);
         if (!z_stall && z_idle == 0) begin
            z_idle = k;
            @(posedge clk);
            #1;
            z_stb = 1'b0;
         end
      end
      z_cyc = 1'b0;
      check("ws0_first_ack", z_ack1, 3);
      check("ws0_second_ack", z_ack2, 7);
      check("ws0_accept_cycle", z_idle, 4);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/wb_sram_slave.md
WB_SRAM_SLAVE -- requirements
Module: wb_sram_slave

Interface
REQ-001 Parameters SHALL be: WIDTH, default 8, data width; ADDR_LINES, default 16, address width; WAIT_STATES, default 2, extra SRAM access cycles (0..15); WP_BASE, default 16'hF000, write-protect match value; WP_MASK, default 16'hF000, write-protect match mask.
REQ-002 i_clk  in  1  sole clock; all logic on rising edge.
REQ-003 i_rst  in  1  synchronous, active-high reset.
REQ-004 i_wb_cyc, i_wb_stb, i_wb_we  in  1 each  Wishbone cycle, strobe, write-enable from upstream S100 bus master.
REQ-005 i_wb_addr  in  ADDR_LINES  and  i_wb_data  in  WIDTH  request address and write data.
REQ-006 o_wb_ack  out  1  registered acknowledge; o_wb_stall  out  1  request not accepted; o_wb_data  out  WIDTH  registered read data.
REQ-007 o_sram_addr  out  ADDR_LINES; o_sram_dq_out  out  WIDTH; o_sram_dq_oe  out  1  drive enable for external tristate.
REQ-008 i_sram_dq_in  in  WIDTH  SRAM read data.
REQ-009 o_sram_ce_n, o_sram_oe_n, o_sram_we_n  out  1 each  active-low SRAM strobes.
REQ-010 o_wp_fault  out  1  one-cycle pulse coincident with ack of a blocked write.

Function
REQ-011 FSM states SHALL be IDLE, SETUP, ACCESS, HOLD.
REQ-012 o_wb_stall SHALL be combinational: 0 in IDLE, 1 in all other states.
REQ-013 IDLE: if i_wb_cyc && i_wb_stb at edge T, latch addr, data, we; enter SETUP at T+1; otherwise remain IDLE.
REQ-014 SETUP (1 cycle): ce_n=0, addr driven; read: oe_n=0; write: dq_oe=1, dq_out=latched data; load wait counter with WAIT_STATES; next ACCESS.
REQ-015 ACCESS: lasts WAIT_STATES+1 cycles; write: we_n=0 throughout; counter decrements each cycle; at counter==0 a read SHALL capture i_sram_dq_in into o_wb_data, then enter HOLD.
REQ-016 HOLD (1 cycle): we_n=1, oe_n=1, ce_n=0, dq_oe held for writes (data hold time); o_wb_ack=1; next IDLE.
REQ-017 Latency: accept at edge T -> ack high during cycle T+3+WAIT_STATES; back-to-back requests SHALL be accepted at the first IDLE cycle, no extra bubble.
REQ-018 we_n and oe_n SHALL never be low simultaneously; dq_oe SHALL be 0 whenever oe_n=0.
REQ-019 If i_wb_cyc drops mid-transaction the SRAM cycle SHALL complete with unchanged timing; ack SHALL be suppressed when i_wb_cyc=0 in HOLD.
REQ-020 o_wb_data SHALL hold its last value between reads; writes do not alter it.
REQ-021 Counter width SHALL be 4 bits; WAIT_STATES=0 gives single-cycle ACCESS.

Reset
REQ-022 i_rst SHALL, at the next edge, force IDLE, o_wb_ack=0, o_wp_fault=0, ce_n=oe_n=we_n=1, dq_oe=0, o_wb_data=0, o_sram_addr=0, counter=0.
REQ-023 Reset mid-write SHALL deassert we_n at that edge; the aborted transaction is never acked.
REQ-024 Power-up register values SHALL equal reset values.

Configuration
REQ-025 Macro WB_SRAM_WRITE_PROTECT_EN: defined -> write with (addr & WP_MASK)==WP_BASE runs full FSM timing with we_n=1 and dq_oe=0 throughout, is acked, and pulses o_wp_fault with ack.
REQ-026 Undefined -> all writes performed; o_wp_fault tied 0; WP_BASE/WP_MASK unused.

Structure
REQ-027 Shared package s100_pkg SHALL hold the FSM state enum, default WIDTH/ADDR_LINES constants and the 4-bit wait-counter width constant.
REQ-028 No sub-module; FSM, counter and write-protect compare SHALL be inline.

Verification (WAIT_STATES=2 unless stated)
REQ-029 Write 8'hA5 to 16'h1234 -> stall 1 from T+1, we_n low exactly 3 cycles, dq_out=8'hA5, ack single cycle at T+5, stall 0 at T+6.
REQ-030 Read 16'h1234 with i_sram_dq_in=8'h3C -> oe_n low T+1..T+4, o_wb_data=8'h3C with ack at T+5, we_n stays 1.
REQ-031 WAIT_STATES=0, back-to-back write then read -> acks at T+3 and T+7, second request accepted at T+4.
REQ-032 i_rst asserted during ACCESS of a write -> next edge we_n=1, ce_n=1, dq_oe=0, no ack ever issued; following request completes normally.
REQ-033 Macro defined, write 8'h55 to 16'hF010 -> we_n never low, ack at T+5 with o_wp_fault=1; read-back returns prior contents; macro undefined -> write performed, o_wp_fault=0.
REQ-034 i_wb_cyc dropped in SETUP of a read -> strobes complete as in REQ-030, o_wb_ack stays 0.
